// File: rtl/benes_route_ctrl_pkg.sv
// Shared sizes, select-bus type and FSM state encoding for the Benes route controller.
// Table dimensions and hold-count width live here so the bench and RTL agree.
package benes_route_ctrl_pkg;

  localparam int STAGE_NUM  = 5;
  localparam int SWITCH_NUM = 16;
  localparam int CTX_NUM    = 16;
  localparam int HOLD_W     = 8;
  localparam int CTX_W      = $clog2(CTX_NUM);
  localparam int STAGE_W    = $clog2(STAGE_NUM);

  typedef logic [SWITCH_NUM-1:0] sw_row_t;
  typedef sw_row_t benes_sel_t [0:STAGE_NUM-1];

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ACTIVE
  } route_state_e;

  // Range check done in 32 bits so narrow index fields never give a constant-folded compare.
  function automatic logic idx_ok(input int unsigned idx, input int unsigned lim);
    return idx < lim;
  endfunction

endpackage

// File: rtl/benes_route_ctrl_sel_skew.sv
// Triangular delay line: stage s of the select bus is delayed by s cycles (stage 0 passes through).
// No backpressure; one register per stage per cycle of delay, all cleared by reset.
module benes_sel_skew
  import benes_route_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  benes_sel_t sel_in,
  output benes_sel_t sel_out
);

  for (genvar s = 0; s < STAGE_NUM; s++) begin : g_stage
    if (s == 0) begin : g_pass
      assign sel_out[0] = sel_in[0];
    end else begin : g_dly
      logic [SWITCH_NUM-1:0] dly [0:s-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < s; i++) begin
            dly[i] <= '0;
          end
        end else begin
          dly[0] <= sel_in[s];
          for (int i = 1; i < s; i++) begin
            dly[i] <= dly[i-1];
          end
        end
      end

      assign sel_out[s] = dly[s-1];
    end
  end

endmodule

// File: rtl/benes_route_ctrl.sv
// Route-context controller: request -> FETCH -> selects driven for hold+1 cycles from edge T+2.
// BENES_SEL_SKEW_EN skews stage s by s cycles and extends o_busy for the flush; req_ready only in IDLE or last ACTIVE cycle.
module benes_route_ctrl
  import benes_route_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_wr_en,
  input  logic                  cfg_wr_dir,
  input  logic [CTX_W-1:0]      cfg_wr_ctx,
  input  logic [STAGE_W-1:0]    cfg_wr_stage,
  input  logic [SWITCH_NUM-1:0] cfg_wr_data,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [CTX_W-1:0]      req_r2m_ctx,
  input  logic [CTX_W-1:0]      req_m2r_ctx,
  input  logic [HOLD_W-1:0]     req_hold,
  output benes_sel_t            o_module_select,
  output benes_sel_t            o_slot_select,
  output logic                  o_route_active,
  output logic                  o_busy
);

`ifdef BENES_SEL_SKEW_EN
  localparam int FLUSH_N = STAGE_NUM - 1;
`else
  localparam int FLUSH_N = 0;
`endif

  benes_sel_t tbl_r2m [CTX_NUM];
  benes_sel_t tbl_m2r [CTX_NUM];

  route_state_e          state;
  logic [CTX_W-1:0]      r2m_ctx_q;
  logic [CTX_W-1:0]      m2r_ctx_q;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [STAGE_W-1:0]    flush_cnt;
  logic                  ready_q;
  logic                  active_q;
  logic                  busy_q;
  benes_sel_t            fetch_r2m;
  benes_sel_t            fetch_m2r;
  benes_sel_t            sel_r2m;
  benes_sel_t            sel_m2r;
  logic                  wr_ok;
  logic                  hs;

  assign wr_ok = cfg_wr_en
              && idx_ok(32'(cfg_wr_ctx), CTX_NUM)
              && idx_ok(32'(cfg_wr_stage), STAGE_NUM);
  assign hs    = req_valid && ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CTX_NUM; c++) begin
        for (int s = 0; s < STAGE_NUM; s++) begin
          tbl_r2m[c][s] <= '0;
          tbl_m2r[c][s] <= '0;
        end
      end
    end else if (wr_ok) begin
      if (cfg_wr_dir) begin
        tbl_m2r[cfg_wr_ctx][cfg_wr_stage] <= cfg_wr_data;
      end else begin
        tbl_r2m[cfg_wr_ctx][cfg_wr_stage] <= cfg_wr_data;
      end
    end
  end

  // The FETCH read samples the table before this edge's write lands, so a colliding write reads old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      r2m_ctx_q <= '0;
      m2r_ctx_q <= '0;
      hold_cnt  <= '0;
      flush_cnt <= '0;
      ready_q   <= 1'b1;
      for (int s = 0; s < STAGE_NUM; s++) begin
        fetch_r2m[s] <= '0;
        fetch_m2r[s] <= '0;
      end
    end else begin
      if (flush_cnt != '0) begin
        flush_cnt <= flush_cnt - 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (hs) begin
            state     <= ST_FETCH;
            r2m_ctx_q <= req_r2m_ctx;
            m2r_ctx_q <= req_m2r_ctx;
            hold_cnt  <= req_hold;
            ready_q   <= 1'b0;
          end
        end
        ST_FETCH: begin
          fetch_r2m <= tbl_r2m[r2m_ctx_q];
          fetch_m2r <= tbl_m2r[m2r_ctx_q];
          state     <= ST_ACTIVE;
          ready_q   <= (hold_cnt == '0);
        end
        ST_ACTIVE: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
            ready_q  <= (hold_cnt == HOLD_W'(1));
          end else if (hs) begin
            state     <= ST_FETCH;
            r2m_ctx_q <= req_r2m_ctx;
            m2r_ctx_q <= req_m2r_ctx;
            hold_cnt  <= req_hold;
            ready_q   <= 1'b0;
          end else begin
            state     <= ST_IDLE;
            ready_q   <= 1'b1;
            flush_cnt <= STAGE_W'(FLUSH_N);
          end
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Output stage lags the FSM by one edge so selects and route_active appear at T+2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      for (int s = 0; s < STAGE_NUM; s++) begin
        sel_r2m[s] <= '0;
        sel_m2r[s] <= '0;
      end
    end else begin
      active_q <= (state == ST_ACTIVE);
      busy_q   <= (state != ST_IDLE) || (flush_cnt != '0);
      if (state == ST_ACTIVE) begin
        sel_r2m <= fetch_r2m;
        sel_m2r <= fetch_m2r;
      end
    end
  end

  assign req_ready      = ready_q;
  assign o_route_active = active_q;
  assign o_busy         = busy_q;

`ifdef BENES_SEL_SKEW_EN
  benes_sel_skew u_skew_r2m (
    .clk     (clk),
    .rst     (rst),
    .sel_in  (sel_r2m),
    .sel_out (o_module_select)
  );

  benes_sel_skew u_skew_m2r (
    .clk     (clk),
    .rst     (rst),
    .sel_in  (sel_m2r),
    .sel_out (o_slot_select)
  );
`else
  assign o_module_select = sel_r2m;
  assign o_slot_select   = sel_m2r;
`endif

endmodule

// File: tb/tb_benes_route_ctrl.sv
// Bench for benes_route_ctrl: transaction-level timeline model plus directed literal checks and random traffic.
module tb_benes_route_ctrl;
  import benes_route_ctrl_pkg::*;

  localparam int MAXC = 8192;
  localparam int VW   = 2 * STAGE_NUM * SWITCH_NUM;
`ifdef BENES_SEL_SKEW_EN
  localparam bit SKEW = 1'b1;
`else
  localparam bit SKEW = 1'b0;
`endif
  localparam int FL = SKEW ? STAGE_NUM - 1 : 0;

  logic                  clk;
  logic                  rst;
  logic                  cfg_wr_en;
  logic                  cfg_wr_dir;
  logic [CTX_W-1:0]      cfg_wr_ctx;
  logic [STAGE_W-1:0]    cfg_wr_stage;
  logic [SWITCH_NUM-1:0] cfg_wr_data;
  logic                  req_valid;
  logic                  req_ready;
  logic [CTX_W-1:0]      req_r2m_ctx;
  logic [CTX_W-1:0]      req_m2r_ctx;
  logic [HOLD_W-1:0]     req_hold;
  benes_sel_t            o_module_select;
  benes_sel_t            o_slot_select;
  logic                  o_route_active;
  logic                  o_busy;

  benes_route_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_wr_en       (cfg_wr_en),
    .cfg_wr_dir      (cfg_wr_dir),
    .cfg_wr_ctx      (cfg_wr_ctx),
    .cfg_wr_stage    (cfg_wr_stage),
    .cfg_wr_data     (cfg_wr_data),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_r2m_ctx     (req_r2m_ctx),
    .req_m2r_ctx     (req_m2r_ctx),
    .req_hold        (req_hold),
    .o_module_select (o_module_select),
    .o_slot_select   (o_slot_select),
    .o_route_active  (o_route_active),
    .o_busy          (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit in_rst = 1'b1;

  // Reference model: table contents, per-cycle expected flags, and a list of route applications.
  logic [SWITCH_NUM-1:0] m_tbl [2][CTX_NUM][STAGE_NUM];
  bit                    exp_act  [MAXC];
  bit                    exp_busy [MAXC];
  int                    ev_start [$];
  logic [VW-1:0]         ev_val   [$];
  int                    free_cyc = 0;
  bit                    pend     = 1'b0;
  int                    pend_edge, pend_r2m, pend_m2r;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [SWITCH_NUM-1:0] exp_sel(input int dir, input int s, input int c);
    logic [SWITCH_NUM-1:0] r = '0;
    logic [VW-1:0]         t;
    for (int i = 0; i < ev_start.size(); i++) begin
      if (ev_start[i] + (SKEW ? s : 0) <= c) begin
        t = ev_val[i];
        r = t[(dir*STAGE_NUM + s)*SWITCH_NUM +: SWITCH_NUM];
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CTX_NUM; c++)
        for (int s = 0; s < STAGE_NUM; s++)
          m_tbl[d][c][s] = '0;
    ev_start.delete();
    ev_val.delete();
    pend     = 1'b0;
    free_cyc = cyc;
    for (int c = cyc; c < MAXC; c++) begin
      exp_act[c]  = 1'b0;
      exp_busy[c] = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    logic [VW-1:0] v;
    int            h;
    cyc = cyc + 1;
    if (!in_rst) begin
      if (pend && pend_edge == cyc) begin
        for (int s = 0; s < STAGE_NUM; s++) begin
          v[s*SWITCH_NUM +: SWITCH_NUM]               = m_tbl[0][pend_r2m][s];
          v[(STAGE_NUM+s)*SWITCH_NUM +: SWITCH_NUM]   = m_tbl[1][pend_m2r][s];
        end
        ev_start.push_back(cyc + 1);
        ev_val.push_back(v);
        pend = 1'b0;
      end
      if (req_valid && (cyc - 1 >= free_cyc)) begin
        h        = int'(req_hold);
        free_cyc = cyc + 1 + h;
        for (int c = cyc + 2; c <= cyc + 2 + h && c < MAXC; c++) exp_act[c] = 1'b1;
        for (int c = cyc + 1; c <= cyc + 2 + h + FL && c < MAXC; c++) exp_busy[c] = 1'b1;
        pend      = 1'b1;
        pend_edge = cyc + 1;
        pend_r2m  = int'(req_r2m_ctx);
        pend_m2r  = int'(req_m2r_ctx);
      end
      if (cfg_wr_en && int'(cfg_wr_stage) < STAGE_NUM)
        m_tbl[cfg_wr_dir][cfg_wr_ctx][cfg_wr_stage] = cfg_wr_data;
    end
  end

  always @(negedge clk) begin
    if (!in_rst && cyc < MAXC) begin
      check("req_ready", 64'(req_ready), 64'(cyc >= free_cyc));
      check("route_active", 64'(o_route_active), 64'(exp_act[cyc]));
      check("busy", 64'(o_busy), 64'(exp_busy[cyc]));
      for (int s = 0; s < STAGE_NUM; s++) begin
        check($sformatf("module_select[%0d]", s), 64'(o_module_select[s]), 64'(exp_sel(0, s, cyc)));
        check($sformatf("slot_select[%0d]", s), 64'(o_slot_select[s]), 64'(exp_sel(1, s, cyc)));
      end
    end
  end

  task automatic do_write(input int dir, input int ctx, input int stage, input int data);
    cfg_wr_en    = 1'b1;
    cfg_wr_dir   = dir[0];
    cfg_wr_ctx   = CTX_W'(ctx);
    cfg_wr_stage = STAGE_W'(stage);
    cfg_wr_data  = SWITCH_NUM'(data);
    @(posedge clk);
    #1;
    cfg_wr_en = 1'b0;
  endtask

  // Returns with t = handshake edge, #1 into the FETCH cycle.
  task automatic send_req(input int r, input int m, input int h, output int t);
    int k = 0;
    req_valid   = 1'b1;
    req_r2m_ctx = CTX_W'(r);
    req_m2r_ctx = CTX_W'(m);
    req_hold    = HOLD_W'(h);
    t = -1;
    while (k < 200) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        t = cyc;
        break;
      end
      k++;
    end
    req_valid = 1'b0;
    if (t < 0) check("req_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_cyc(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  initial begin
    int t, ta, tb, acnt, bcnt;
    bit hs;
    rst = 1'b1; cfg_wr_en = 1'b0; cfg_wr_dir = 1'b0; cfg_wr_ctx = '0; cfg_wr_stage = '0;
    cfg_wr_data = '0; req_valid = 1'b0; req_r2m_ctx = '0; req_m2r_ctx = '0; req_hold = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    in_rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'(1));
    check("rst_active", 64'(o_route_active), 64'(0));
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_mod_sel0", 64'(o_module_select[0]), 64'(0));

    // Basic route with literal expectations.
    @(posedge clk); #1;
    do_write(0, 3, 2, 16'hA5A5);
    do_write(1, 7, 0, 16'h00FF);
    send_req(3, 7, 2, t);
    acnt = 0; bcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      acnt += int'(o_route_active);
      bcnt += int'(o_busy);
      if (cyc == t + 2)
        check("lit_stage2_at_T2", 64'(o_module_select[2]), SKEW ? 64'(0) : 64'(16'hA5A5));
      if (cyc == t + 4) begin
        check("lit_mod_sel2", 64'(o_module_select[2]), 64'(16'hA5A5));
        check("lit_slot_sel0", 64'(o_slot_select[0]), 64'(16'h00FF));
      end
    end
    check("lit_active_len", 64'(acnt), 64'(3));
    check("lit_busy_len", 64'(bcnt), 64'(4 + FL));

    // Write colliding with FETCH returns old data; the next fetch sees the new value.
    @(posedge clk); #1;
    send_req(3, 7, 1, t);
    do_write(0, 3, 2, 16'h1234);
    wait_cyc(t + 5);
    check("lit_collide_old", 64'(o_module_select[2]), 64'(16'hA5A5));
    repeat (6) @(posedge clk); #1;
    send_req(3, 7, 0, t);
    wait_cyc(t + 5);
    check("lit_collide_new", 64'(o_module_select[2]), 64'(16'h1234));

    // Out-of-range stage writes are dropped.
    repeat (6) @(posedge clk); #1;
    do_write(0, 3, 5, 16'hFFFF);
    do_write(1, 7, 7, 16'hFFFF);
    send_req(3, 7, 0, t);
    wait_cyc(t + 7);
    check("lit_stage5_ign", 64'(o_module_select[4]), 64'(0));
    check("lit_stage5_keep", 64'(o_module_select[2]), 64'(16'h1234));

    // Back-to-back: second request accepted on the last ACTIVE cycle, one bubble.
    repeat (6) @(posedge clk); #1;
    do_write(0, 1, 0, 16'hBEEF);
    send_req(1, 2, 3, ta);
    send_req(3, 7, 2, tb);
    check("lit_b2b_edge", 64'(tb), 64'(ta + 5));
    wait_cyc(tb + 1);
    check("lit_bubble_active", 64'(o_route_active), 64'(0));
    check("lit_bubble_hold", 64'(o_module_select[0]), 64'(16'hBEEF));
    wait_cyc(tb + 2);
    check("lit_b2b_active", 64'(o_route_active), 64'(1));

    // Reset during ACTIVE.
    repeat (10) @(posedge clk); #1;
    send_req(3, 7, 10, t);
    wait_cyc(t + 5);
    @(posedge clk); #1;
    in_rst = 1'b1;
    rst    = 1'b1;
    #1;
    check("lit_rst_mod_sel2", 64'(o_module_select[2]), 64'(0));
    check("lit_rst_slot_sel0", 64'(o_slot_select[0]), 64'(0));
    check("lit_rst_active", 64'(o_route_active), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    in_rst = 1'b0;
    @(negedge clk);
    check("lit_rst_ready", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    send_req(3, 7, 0, t);
    wait_cyc(t + 7);
    check("lit_rst_tbl_r2m", 64'(o_module_select[2]), 64'(0));
    check("lit_rst_tbl_m2r", 64'(o_slot_select[0]), 64'(0));

    // Random traffic against the model.
    @(posedge clk); #1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      hs = req_valid && req_ready;
      @(posedge clk);
      #1;
      if (hs || !req_valid) begin
        if ($urandom_range(0, 2) == 0) begin
          req_valid   = 1'b1;
          req_r2m_ctx = CTX_W'($urandom_range(0, CTX_NUM - 1));
          req_m2r_ctx = CTX_W'($urandom_range(0, CTX_NUM - 1));
          req_hold    = HOLD_W'($urandom_range(0, 6));
        end else begin
          req_valid = 1'b0;
        end
      end
      cfg_wr_en    = ($urandom_range(0, 2) == 0);
      cfg_wr_dir   = 1'($urandom_range(0, 1));
      cfg_wr_ctx   = CTX_W'($urandom_range(0, CTX_NUM - 1));
      cfg_wr_stage = STAGE_W'($urandom_range(0, 7));
      cfg_wr_data  = SWITCH_NUM'($urandom);
    end
    req_valid = 1'b0;
    cfg_wr_en = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
